uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 68 ++++++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter and receiver.
//   - parity-mode codes and the decode from the PARITY character parameter
//   - FSM state enum
//   - clocks-per-bit, stop-length and frame-bit-count helpers
//   - parity bit generation
package uart_pkg;

    // Parity modes, decoded once from the PARITY character parameter
    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_ODD   = 3'd1;
    localparam logic [2:0] PAR_EVEN  = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // "N", "O", "E", "M", "S"; anything else falls back to no parity
    function automatic logic [2:0] parity_mode(input logic [7:0] p);
        case (p)
            "O":     return PAR_ODD;
            "E":     return PAR_EVEN;
            "M":     return PAR_MARK;
            "S":     return PAR_SPACE;
            default: return PAR_NONE;
        endcase
    endfunction

    // Clocks per bit; integer division, remainder is dropped
    function automatic int unsigned calc_cntdiv(input int unsigned freq,
                                                input int unsigned baud);
        return freq / baud;
    endfunction

    // Stop length in clocks. stop_halves is the stop-bit count in half bits
    // (2 = 1.0, 3 = 1.5, 4 = 2.0); the half bit rounds down.
    function automatic int unsigned calc_slen(input int unsigned cntdiv,
                                              input int unsigned stop_halves);
        case (stop_halves)
            3:       return cntdiv + cntdiv / 2;
            4:       return 2 * cntdiv;
            default: return cntdiv;
        endcase
    endfunction

    // Bits in a frame before the stop bits: start + data + optional parity
    function automatic int unsigned calc_bitnum(input int unsigned databits,
                                                input logic [2:0]  mode);
        return 1 + databits + ((mode != PAR_NONE) ? 1 : 0);
    endfunction

    // Parity over a word zero-extended to 9 bits (padding does not change ^)
    function automatic logic parity_bit(input logic [2:0] mode,
                                        input logic [8:0] data);
        case (mode)
            PAR_ODD:  return ~^data;
            PAR_EVEN: return ^data;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period counter with a programmable
// terminal count. While enabled it counts 0..I_term and strobes O_tick on
// the last clock of the period, wrapping to 0 on the same edge. Disabled or
// in reset it is held at 0, so a new period always starts cleanly.
//
// Ports:
//   I_clk   system clock
//   I_rst   synchronous active-high reset
//   I_en    count enable
//   I_term  terminal count (period length - 1)
//   O_tick  high on the final clock of each period
module uart_baud_tick #(
    parameter int unsigned TW = 8
) (
    input  logic          I_clk,
    input  logic          I_rst,
    input  logic          I_en,
    input  logic [TW-1:0] I_term,
    output logic          O_tick
);

    logic [TW-1:0] cnt;

    assign O_tick = I_en && (cnt == I_term);

    always_ff @(posedge I_clk) begin
        if (I_rst || !I_en) begin
            cnt <= '0;
        end else if (O_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: static-configuration UART transmitter.
// Accepts words over valid/ready into a single-entry buffer and serialises
// frames on O_txd: start bit, data LSB first, optional parity, stop bits.
// Back-to-back words are sent with no idle gap between frames.
//
// Ports:
//   I_clk    system clock
//   I_rst    synchronous active-high reset (aborts any frame in flight)
//   I_data   word to send (DATABITS wide)
//   I_valid  I_data is valid; transfer when I_valid && O_ready
//   O_ready  buffer is empty and can take a word
//   O_busy   a frame is on the line (FSM not idle)
//   O_txd    serial output, idle high, registered
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned FREQUENCY = 50000000,
    parameter int unsigned BAUDRATE  = 9600,
    parameter int unsigned DATABITS  = 8,
    parameter logic [7:0]  PARITY    = "N",
    parameter real         STOPBITS  = 1.0
) (
    input  logic                I_clk,
    input  logic                I_rst,
    input  logic [DATABITS-1:0] I_data,
    input  logic                I_valid,
    output logic                O_ready,
    output logic                O_busy,
    output logic                O_txd
);

    localparam int unsigned CNTDIV      = calc_cntdiv(FREQUENCY, BAUDRATE);
    localparam int unsigned STOP_HALVES = (STOPBITS == 1.5) ? 3 :
                                          ((STOPBITS == 2.0) ? 4 : 2);
    localparam int unsigned SLEN        = calc_slen(CNTDIV, STOP_HALVES);
    // Sized for the longest period (2.0 stop bits) so one counter serves all
    localparam int unsigned TW          = $clog2(2 * CNTDIV);
    localparam logic [2:0]  PMODE       = parity_mode(PARITY);
    localparam logic [TW-1:0] TERM_BIT  = TW'(CNTDIV - 1);
    localparam logic [TW-1:0] TERM_STOP = TW'(SLEN - 1);
    localparam logic [3:0]  LAST_BIT    = 4'(DATABITS - 1);

    uart_state_e           state;
    logic                  buf_full;
    logic [DATABITS-1:0]   buf_q;
    logic [DATABITS-1:0]   shreg;
    logic                  par_q;
    logic [3:0]            bit_idx;
    logic                  txd_q;

    logic                  tick;
    logic                  cnt_en;
    logic [TW-1:0]         term;
    logic                  accept;
    logic                  load;
    logic                  par_new;
    logic                  txd_next;

    // Ready is purely the buffer state; never a function of I_valid
    assign accept  = I_valid && !buf_full;
    // Buffer drains into the shifter from IDLE, or on the last stop clock so
    // the next start bit follows with no gap
    assign load    = buf_full && ((state == ST_IDLE) ||
                                  ((state == ST_STOP) && tick));
    assign par_new = parity_bit(PMODE, 9'(buf_q));

    assign cnt_en  = (state != ST_IDLE);
    assign term    = (state == ST_STOP) ? TERM_STOP : TERM_BIT;

    uart_baud_tick #(
        .TW     (TW)
    ) u_tick (
        .I_clk  (I_clk),
        .I_rst  (I_rst),
        .I_en   (cnt_en),
        .I_term (term),
        .O_tick (tick)
    );

    // Line level for the current state; registered below, so O_txd lags the
    // FSM by one clock (START entered at N+1, line low from N+2)
    always_comb begin
        txd_next = 1'b1;
        case (state)
            ST_START:  txd_next = 1'b0;
            ST_DATA:   txd_next = shreg[0];
            ST_PARITY: txd_next = par_q;
            default:   txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state    <= ST_IDLE;
            buf_full <= 1'b0;
            buf_q    <= '0;
            shreg    <= '0;
            par_q    <= 1'b0;
            bit_idx  <= '0;
            txd_q    <= 1'b1;
        end else begin
            txd_q <= txd_next;

            if (load) begin
                buf_full <= 1'b0;
                shreg    <= buf_q;
                par_q    <= par_new;
                bit_idx  <= '0;
            end
            // accept needs an empty buffer and load needs a full one, so the
            // two never collide on the same edge
            if (accept) begin
                buf_full <= 1'b1;
                buf_q    <= I_data;
            end

            case (state)
                ST_IDLE: begin
                    if (load) state <= ST_START;
                end
                ST_START: begin
                    if (tick) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg <= shreg >> 1;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            state   <= (PMODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (tick) state <= load ? ST_START : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign O_ready = !buf_full;
    assign O_busy  = (state != ST_IDLE);
    assign O_txd   = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: eight transmitter configurations side by side (1 MHz clock,
// 100 kbaud, 10 clocks per bit). A line monitor per lane decodes frames and
// compares them against a scoreboard filled when words are driven.
module tb_uart_tx;

    localparam int NCFG = 8;
    // lane:                              8N1  8E1  8O1  8M1  8S1 8N1.5 8N2 5N1
    localparam int         CFG_DB  [NCFG] = '{8,   8,   8,   8,   8,   8,   8,   5};
    localparam logic [7:0] CFG_PAR [NCFG] = '{"N", "E", "O", "M", "S", "N", "N", "N"};
    localparam int         CFG_SH  [NCFG] = '{2,   2,   2,   2,   2,   3,   4,   2};
    localparam int         CFG_HP  [NCFG] = '{0,   1,   1,   1,   1,   0,   0,   0};
    localparam int         CFG_SLEN[NCFG] = '{10,  10,  10,  10,  10,  15,  20,  10};

    typedef struct {
        int         lane;
        logic [7:0] din;
        logic [8:0] dexp;
        logic       par;
        int         flen;
    } vec_t;

    typedef struct {
        int         lane;
        logic [8:0] data;
        logic       par;
        int         start;
    } sb_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NCFG-1:0]            valid = '0;
    logic [NCFG-1:0]            ready;
    logic [NCFG-1:0]            busy;
    logic [NCFG-1:0]            txd;
    logic [NCFG-1:0][7:0]       ldata = '0;
    int                         cyc = 0;
    int                         errs = 0;
    int                         checks = 0;
    sb_t                        sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        uart_tx #(
            .FREQUENCY (1000000),
            .BAUDRATE  (100000),
            .DATABITS  (CFG_DB[g]),
            .PARITY    (CFG_PAR[g]),
            .STOPBITS  (CFG_SH[g] * 0.5)
        ) u_dut (
            .I_clk   (clk),
            .I_rst   (rst),
            .I_data  (ldata[g][CFG_DB[g]-1:0]),
            .I_valid (valid[g]),
            .O_ready (ready[g]),
            .O_busy  (busy[g]),
            .O_txd   (txd[g])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int lane, input logic [8:0] d, input logic p,
                            input int start);
        sb_t e;
        e.lane  = lane;
        e.data  = d;
        e.par   = p;
        e.start = start;
        sb.push_back(e);
    endtask

    // ---------------- line monitor ----------------
    bit          m_act [NCFG];
    int          m_t   [NCFG];
    int          m_st  [NCFG];
    bit          m_stop[NCFG];
    logic [10:0] m_bits[NCFG];

    task automatic frame_done(input int g);
        sb_t        e;
        logic [8:0] d;
        d = '0;
        for (int i = 0; i < CFG_DB[g]; i++) d[i] = m_bits[g][1+i];
        chk("frame_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("frame_lane", g, e.lane);
            chk("frame_start_cycle", m_st[g], e.start);
            chk("frame_start_bit", int'(m_bits[g][0]), 0);
            chk("frame_data", int'(d), int'(e.data));
            if (CFG_HP[g] != 0)
                chk("frame_parity", int'(m_bits[g][1+CFG_DB[g]]), int'(e.par));
            chk("frame_stop_high", int'(m_stop[g]), 1);
        end
    endtask

    always @(negedge clk) begin
        int nb;
        for (int g = 0; g < NCFG; g++) begin
            nb = 1 + CFG_DB[g] + CFG_HP[g];
            if (rst) begin
                m_act[g] = 1'b0;
            end else if (!m_act[g]) begin
                if (txd[g] == 1'b0) begin
                    m_act[g]  = 1'b1;
                    m_t[g]    = 0;
                    m_st[g]   = cyc;
                    m_stop[g] = 1'b1;
                    m_bits[g] = '0;
                end
            end else begin
                m_t[g]++;
            end
            if (m_act[g]) begin
                if (m_t[g] < nb * 10) begin
                    if (m_t[g] % 10 == 5) m_bits[g][m_t[g] / 10] = txd[g];
                end else if (txd[g] !== 1'b1) begin
                    m_stop[g] = 1'b0;
                end
                if (m_t[g] == nb * 10 + CFG_SLEN[g] - 1) begin
                    m_act[g] = 1'b0;
                    frame_done(g);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Offer a word, wait for ready, return the cycle stamp just after the
    // accepting edge (the start bit is expected two cycles later)
    task automatic send(input int g, input logic [7:0] d, output int acc);
        int n;
        @(negedge clk);
        valid[g] = 1'b1;
        ldata[g] = d;
        n = 0;
        while (!ready[g] && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", int'(ready[g]), 1);
        @(posedge clk);
        #1;
        acc      = cyc;
        valid[g] = 1'b0;
        ldata[g] = 8'($urandom);
    endtask

    task automatic run_vec(input vec_t v);
        int acc, k, len;
        send(v.lane, v.din, acc);
        push_exp(v.lane, v.dexp, v.par, acc + 2);
        k = 0;
        while (!busy[v.lane] && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("busy_rise_cycle", cyc, acc + 1);
        len = 0;
        while (busy[v.lane] && len < 400) begin
            @(negedge clk);
            len++;
        end
        chk("busy_frame_len", len, v.flen);
        repeat (2) @(negedge clk);
        chk("idle_txd_after", int'(txd[v.lane]), 1);
        chk("idle_ready_after", int'(ready[v.lane]), 1);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    vec_t vecs[8];

    initial begin
        int acc, n, zeros;

        vecs[0] = '{0, 8'h55, 9'h055, 1'b0, 100};
        vecs[1] = '{1, 8'hA5, 9'h0A5, 1'b0, 110};
        vecs[2] = '{2, 8'hA5, 9'h0A5, 1'b1, 110};
        vecs[3] = '{3, 8'h00, 9'h000, 1'b1, 110};
        vecs[4] = '{4, 8'h00, 9'h000, 1'b0, 110};
        vecs[5] = '{5, 8'h3C, 9'h03C, 1'b0, 105};
        vecs[6] = '{6, 8'hC3, 9'h0C3, 1'b0, 110};
        vecs[7] = '{7, 8'hFF, 9'h01F, 1'b0, 70};

        // reset state
        rst = 1'b1;
        valid = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_txd", int'(txd), (1 << NCFG) - 1);
        chk("reset_ready", int'(ready), (1 << NCFG) - 1);
        chk("reset_busy", int'(busy), 0);
        valid = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single frames across all formats
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // back-to-back on 8N1: valid held, 0x00 then 0xFF
        @(negedge clk);
        valid[0] = 1'b1;
        ldata[0] = 8'h00;
        @(posedge clk);
        #1;
        acc = cyc;
        ldata[0] = 8'hFF;
        push_exp(0, 9'h000, 1'b0, acc + 2);
        n = 0;
        while (!ready[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_ready_after_load", int'(ready[0]), 1);
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        push_exp(0, 9'h0FF, 1'b0, acc + 102);
        @(negedge clk);
        n = 0;
        while (!ready[0] && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_ready_low_cycles", n, 99);
        n = 0;
        while (busy[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("b2b_busy_total_end", cyc, acc + 201 + 2);
        chk("b2b_scoreboard_drained", sb.size(), 0);

        // reset mid-frame with a second word buffered: nothing goes out
        send(0, 8'h12, acc);
        @(negedge clk);
        valid[0] = 1'b1;
        ldata[0] = 8'h34;
        n = 0;
        while (!ready[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_mid_buffer_full", int'(ready[0]), 0);
        while (cyc < acc + 37) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_txd", int'(txd[0]), 1);
        chk("rst_mid_ready", int'(ready[0]), 1);
        chk("rst_mid_busy", int'(busy[0]), 0);
        zeros = 0;
        repeat (250) begin
            @(negedge clk);
            if (txd[0] !== 1'b1) zeros++;
        end
        chk("rst_mid_line_quiet", zeros, 0);
        chk("rst_mid_busy_after", int'(busy[0]), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errs, checks);
        $fatal(1, "watchdog");
    end

endmodule
